puf_challenge_seq: RTL and testbench
====================================

Name: puf_challenge_seq

Overview:
- Sits directly downstream of the 64-bit challenge LFSR and upstream of the response packer/UART path.
- Per challenge, it:
  - latches the LFSR state as the arbiter PUF challenge;
  - fires the PUF trigger REPS times;
  - synchronizes and samples each response;
  - majority-votes the samples;
  - emits a {challenge, response, ones-count} record over a valid/ready handshake.
- After each record is accepted, it steps the LFSR by one and repeats until the programmed challenge count is exhausted.

Parameters:
- W, 64: challenge width; matches the LFSR width.
- REPS, 7: trigger/sample repetitions per challenge. Must be odd, range 1..255.
- ARM_CYC, 4: cycles the challenge is held stable with trigger low before each fire. Must be ≥1.
- SETTLE_CYC, 16: cycles after fire before the response is sampled. Must be ≥3, which covers the 2-FF sync.

Ports:
- clk, in, 1: system clock.
- rstn, in, 1: synchronous active-low reset.
- start, in, 1: begin a run. Sampled only in IDLE; ignored otherwise.
- num_chal, in, 16: number of challenges in the run. Latched on accepted start.
- lfsr_state, in, W: current LFSR state.
- lfsr_en, out, 1: one-cycle advance pulse to the LFSR.
- challenge, out, W: registered challenge driven to the PUF delay chains.
- puf_trig, out, 1: registered PUF trigger.
- puf_resp, in, 1: asynchronous arbiter output.
- out_valid, out, 1: record valid.
- out_ready, in, 1: downstream ready.
- out_chal, out, W: challenge of the current record.
- out_resp, out, 1: majority-voted response bit.
- out_ones, out, 8: count of 1 samples out of REPS.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at end of run.

Behaviour:
- Reset (rstn=0 at a clk edge) returns the block to IDLE and zeroes:
  - all outputs, including challenge, puf_trig, lfsr_en, out_valid and done;
  - rem, rep_cnt, ones and both sync flops.
- Reset mid-run abandons the run immediately. No record is emitted and no done pulse is produced.
- puf_resp passes through a 2-FF synchronizer; resp_s is the second stage. Only resp_s is ever used.
- All outputs are registered; none is a combinational function of inputs.
- FSM, one transition per clk:
  - IDLE:
    - start=1 and num_chal≠0: rem<=num_chal → LOAD.
    - start=1 and num_chal=0: done=1 for one cycle; stay in IDLE.
  - LOAD (1 cycle): challenge<=lfsr_state, rep_cnt<=0, ones<=0 → ARM.
  - ARM (ARM_CYC cycles): puf_trig=0 and challenge stable → FIRE.
  - FIRE (1 cycle): puf_trig=1 → WAIT.
  - WAIT (SETTLE_CYC cycles): puf_trig=0 → SAMPLE.
  - SAMPLE (1 cycle): ones<=ones+resp_s, rep_cnt<=rep_cnt+1.
    - rep_cnt=REPS-1 → EMIT.
    - Otherwise → ARM.
  - EMIT: out_valid=1, out_chal=challenge, out_ones=ones, out_resp=(ones > REPS/2), using integer division.
    - Record fields are stable while out_valid=1.
    - On out_valid&&out_ready → ADVANCE, with out_valid=0 next cycle.
    - Backpressure of any length holds EMIT indefinitely with puf_trig=0.
  - ADVANCE (1 cycle): lfsr_en=1, rem<=rem-1.
    - rem=1 → DONE.
    - Otherwise → LOAD; the next LOAD captures the already-stepped lfsr_state.
  - DONE (1 cycle): done=1 → IDLE.
- lfsr_en is asserted only in ADVANCE; exactly one pulse per accepted record.
- Timing per challenge, from LOAD entry to EMIT: 1 + REPS×(ARM_CYC+1+SETTLE_CYC+1) cycles.
- ones is 8 bits wide; REPS≤255 guarantees it never overflows.
- num_chal=65535 is legal: the run issues 65535 records. rem never wraps.
- A start pulse while busy has no effect and does not reload rem.

Test Plan:
- Single challenge, with REPS=3, ARM_CYC=2, SETTLE_CYC=4, num_chal=1, lfsr_state=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1, puf_resp=1, start in cycle 0:
  - LOAD in cycle 1; puf_trig high in cycles 4, 12 and 20 only.
  - out_valid in cycle 26 with out_chal=all-ones, out_ones=3, out_resp=1.
  - lfsr_en in cycle 27; done in cycle 28.
- Majority vote: same setup with puf_resp driven 1,0,0 around the three SAMPLE cycles → out_ones=1, out_resp=0. Then 1,1,0 → out_ones=2, out_resp=1.
- Multi-challenge with a real LFSR model attached, num_chal=3 → 3 records whose out_chal values equal successive LFSR states; exactly 3 lfsr_en pulses; one done pulse; busy falls the cycle after done.
- Backpressure: hold out_ready=0 for 10 cycles in EMIT → out_valid stays 1 with out_chal/out_resp/out_ones stable, no lfsr_en, puf_trig=0. Release → ADVANCE on the following cycle.
- Boundary: start with num_chal=0 → done pulses one cycle after start is sampled, busy never rises, no lfsr_en. A second start asserted during WAIT → ignored; the record count is unchanged.
- Reset mid-run: rstn=0 for one cycle during the second WAIT → all outputs 0 on the next cycle, FSM in IDLE, no done. A fresh start then runs correctly from LOAD.

Source files
------------

// File: rtl/puf_challenge_seq.sv
// puf_challenge_seq
//   Drives an arbiter PUF from a 64-bit challenge LFSR. For each challenge it
//   latches the LFSR state, fires the PUF trigger REPS times, samples the
//   synchronized response after each fire and majority-votes the samples.
//   The resulting {challenge, response, ones-count} record goes out over a
//   valid/ready handshake. Once a record is accepted the LFSR is stepped,
//   and the sequence repeats until num_chal records have been issued.
//
// Ports
//   clk, rstn           system clock, synchronous active-low reset
//   start, num_chal     run request and challenge count (taken only in IDLE)
//   lfsr_state, lfsr_en LFSR state in, one-cycle advance pulse out
//   challenge, puf_trig registered challenge and trigger to the PUF
//   puf_resp            asynchronous arbiter output
//   out_valid/out_ready record handshake
//   out_chal, out_resp, out_ones  record fields
//   busy, done          status: busy outside IDLE, done pulse at end of run
module puf_challenge_seq #(
  parameter int unsigned W          = 64,
  parameter int unsigned REPS       = 7,
  parameter int unsigned ARM_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [15:0]  num_chal,
  input  logic [W-1:0] lfsr_state,
  output logic         lfsr_en,
  output logic [W-1:0] challenge,
  output logic         puf_trig,
  input  logic         puf_resp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_chal,
  output logic         out_resp,
  output logic [7:0]   out_ones,
  output logic         busy,
  output logic         done
);

  if ((REPS % 2) == 0 || REPS < 1 || REPS > 255) begin : g_bad_reps
    $error("REPS must be odd and within 1..255");
  end
  if (ARM_CYC < 1) begin : g_bad_arm
    $error("ARM_CYC must be at least 1");
  end
  if (SETTLE_CYC < 3) begin : g_bad_settle
    $error("SETTLE_CYC must be at least 3");
  end

  localparam int unsigned CMAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ARM_LAST    = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [7:0]    REP_LAST    = 8'(REPS - 1);
  localparam logic [7:0]    HALF        = 8'(REPS / 2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_FIRE,
    S_WAIT,
    S_SAMPLE,
    S_EMIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t        state;
  logic          sync1;
  logic          resp_s;
  logic [15:0]   rem;
  logic [7:0]    rep_cnt;
  logic [7:0]    ones;
  logic [CW-1:0] cnt;
  logic [7:0]    ones_nxt;

  // Tally including the sample taken this cycle; used so the record
  // built on the last SAMPLE already contains the final vote.
  always_comb begin
    ones_nxt = ones + {7'd0, resp_s};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      sync1     <= 1'b0;
      resp_s    <= 1'b0;
      rem       <= '0;
      rep_cnt   <= '0;
      ones      <= '0;
      cnt       <= '0;
      lfsr_en   <= 1'b0;
      challenge <= '0;
      puf_trig  <= 1'b0;
      out_valid <= 1'b0;
      out_chal  <= '0;
      out_resp  <= 1'b0;
      out_ones  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sync1    <= puf_resp;
      resp_s   <= sync1;
      lfsr_en  <= 1'b0;
      done     <= 1'b0;
      puf_trig <= 1'b0;

      // Outputs are assigned on the transition into a state so that they
      // are valid for exactly the cycles spent in that state.
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (num_chal != 16'd0) begin
              rem   <= num_chal;
              busy  <= 1'b1;
              state <= S_LOAD;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          challenge <= lfsr_state;
          rep_cnt   <= '0;
          ones      <= '0;
          cnt       <= '0;
          state     <= S_ARM;
        end

        S_ARM: begin
          if (cnt == ARM_LAST) begin
            cnt      <= '0;
            puf_trig <= 1'b1;
            state    <= S_FIRE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_FIRE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_SAMPLE: begin
          ones    <= ones_nxt;
          rep_cnt <= rep_cnt + 8'd1;
          if (rep_cnt == REP_LAST) begin
            out_valid <= 1'b1;
            out_chal  <= challenge;
            out_ones  <= ones_nxt;
            out_resp  <= (ones_nxt > HALF);
            state     <= S_EMIT;
          end else begin
            state <= S_ARM;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            lfsr_en   <= 1'b1;
            state     <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          rem <= rem - 16'd1;
          if (rem == 16'd1) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_seq.sv
module tb_puf_challenge_seq;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [15:0]  num_chal;
  logic [W-1:0] lfsr_state;
  logic         lfsr_en;
  logic [W-1:0] challenge;
  logic         puf_trig;
  logic         puf_resp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_chal;
  logic         out_resp;
  logic [7:0]   out_ones;
  logic         busy;
  logic         done;

  puf_challenge_seq #(
    .W(64),
    .REPS(3),
    .ARM_CYC(2),
    .SETTLE_CYC(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .num_chal(num_chal),
    .lfsr_state(lfsr_state),
    .lfsr_en(lfsr_en),
    .challenge(challenge),
    .puf_trig(puf_trig),
    .puf_resp(puf_resp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chal(out_chal),
    .out_resp(out_resp),
    .out_ones(out_ones),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] chal;
    logic        resp;
    logic [7:0]  ones;
  } rec_t;

  rec_t sb[$];

  int errors = 0;
  int checks = 0;
  int nadv   = 0;
  int ndone  = 0;
  int nrec   = 0;

  // Attached challenge LFSR (x^64 + x^63 + x^61 + x^60 + 1, Fibonacci form)
  logic        lfsr_set = 1'b0;
  logic [63:0] lfsr_seed = '0;
  logic [63:0] exp_lfsr;

  function automatic logic [63:0] step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  always @(posedge clk) begin
    if (lfsr_set) lfsr_state <= lfsr_seed;
    else if (lfsr_en) lfsr_state <= step(lfsr_state);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record monitor: pops the scoreboard on every accepted handshake.
  always @(negedge clk) begin
    if (lfsr_en === 1'b1) nadv++;
    if (done === 1'b1) ndone++;
    if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      nrec++;
      if (sb.size() == 0) begin
        chk("record_unexpected", 64'd1, 64'd0);
      end else begin
        rec_t e;
        e = sb.pop_front();
        chk("out_chal", out_chal, e.chal);
        chk("out_resp", {63'd0, out_resp}, {63'd0, e.resp});
        chk("out_ones", {56'd0, out_ones}, {56'd0, e.ones});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [15:0] n);
    @(posedge clk); #1;
    start    = 1'b1;
    num_chal = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_trig();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (puf_trig === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("trig_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", {63'd0, ok}, 64'd1);
  endtask

  // pat[r] is the response presented for repetition r.
  task automatic run_rec(input logic [2:0] pat, input bit inject);
    rec_t e;
    int   n;
    n = int'(pat[0]) + int'(pat[1]) + int'(pat[2]);
    e.chal = exp_lfsr;
    e.ones = 8'(n);
    e.resp = (n > 1);
    sb.push_back(e);
    exp_lfsr = step(exp_lfsr);
    for (int r = 0; r < 3; r++) begin
      wait_trig();
      puf_resp = pat[r];
      if (inject && r == 0) begin
        @(posedge clk); #1;
        start    = 1'b1;
        num_chal = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int a0, d0, r0;
    logic [63:0] ec;
    bit ok;

    rstn      = 1'b0;
    start     = 1'b0;
    num_chal  = '0;
    puf_resp  = 1'b1;
    out_ready = 1'b1;

    // Reset state
    lfsr_seed = '1;
    lfsr_set  = 1'b1;
    repeat (3) @(posedge clk);
    #1 lfsr_set = 1'b0;
    exp_lfsr = '1;
    @(negedge clk);
    chk("rst_challenge", challenge, 64'd0);
    chk("rst_trig", {63'd0, puf_trig}, 64'd0);
    chk("rst_lfsr_en", {63'd0, lfsr_en}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single challenge, cycle-exact timeline
    a0 = nadv; r0 = nrec;
    sb.push_back('{chal: 64'hFFFF_FFFF_FFFF_FFFF, resp: 1'b1, ones: 8'd3});
    exp_lfsr = step(exp_lfsr);
    @(posedge clk); #1;
    start    = 1'b1;
    num_chal = 16'd1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("t1_trig_c%0d", c), {63'd0, puf_trig}, {63'd0, (c == 4 || c == 12 || c == 20)});
      chk($sformatf("t1_valid_c%0d", c), {63'd0, out_valid}, {63'd0, (c == 26)});
      chk($sformatf("t1_lfsr_en_c%0d", c), {63'd0, lfsr_en}, {63'd0, (c == 27)});
      chk($sformatf("t1_done_c%0d", c), {63'd0, done}, {63'd0, (c == 28)});
      chk($sformatf("t1_busy_c%0d", c), {63'd0, busy}, {63'd0, (c >= 1 && c <= 28)});
      if (c == 3) chk("t1_challenge", challenge, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("t1_records", 64'(nrec - r0), 64'd1);
    chk("t1_adv", 64'(nadv - a0), 64'd1);

    // Majority vote
    start_run(16'd1);
    run_rec(3'b001, 1'b0);
    wait_done();
    start_run(16'd1);
    run_rec(3'b011, 1'b0);
    wait_done();

    // Multi-challenge with LFSR stepping
    @(negedge clk); #1;
    a0 = nadv; d0 = ndone; r0 = nrec;
    start_run(16'd3);
    run_rec(3'b111, 1'b0);
    run_rec(3'b010, 1'b0);
    run_rec(3'b101, 1'b0);
    wait_done();
    chk("multi_busy_at_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("multi_busy_after", {63'd0, busy}, 64'd0);
    #1;
    chk("multi_adv", 64'(nadv - a0), 64'd3);
    chk("multi_done", 64'(ndone - d0), 64'd1);
    chk("multi_records", 64'(nrec - r0), 64'd3);
    chk("multi_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    ec = exp_lfsr;
    start_run(16'd1);
    run_rec(3'b110, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", {63'd0, ok}, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_chal", out_chal, ec);
      chk("bp_ones", {56'd0, out_ones}, 64'd2);
      chk("bp_resp", {63'd0, out_resp}, 64'd1);
      chk("bp_lfsr_en", {63'd0, lfsr_en}, 64'd0);
      chk("bp_trig", {63'd0, puf_trig}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_release_lfsr_en", {63'd0, lfsr_en}, 64'd0);
    @(negedge clk);
    chk("bp_advance_lfsr_en", {63'd0, lfsr_en}, 64'd1);
    chk("bp_advance_valid", {63'd0, out_valid}, 64'd0);
    wait_done();

    // num_chal = 0
    @(negedge clk); #1;
    a0 = nadv;
    @(posedge clk); #1;
    start    = 1'b1;
    num_chal = 16'd0;
    @(negedge clk);
    chk("zero_done_c0", {63'd0, done}, 64'd0);
    chk("zero_busy_c0", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done_c1", {63'd0, done}, 64'd1);
    chk("zero_busy_c1", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("zero_busy_after", {63'd0, busy}, 64'd0);
      chk("zero_done_after", {63'd0, done}, 64'd0);
    end
    #1;
    chk("zero_adv", 64'(nadv - a0), 64'd0);

    // Start while busy is ignored
    a0 = nadv; d0 = ndone; r0 = nrec;
    start_run(16'd2);
    run_rec(3'b111, 1'b1);
    run_rec(3'b000, 1'b0);
    wait_done();
    repeat (60) @(negedge clk);
    #1;
    chk("inject_records", 64'(nrec - r0), 64'd2);
    chk("inject_adv", 64'(nadv - a0), 64'd2);
    chk("inject_done", 64'(ndone - d0), 64'd1);
    chk("inject_busy", {63'd0, busy}, 64'd0);

    // Reset during the second WAIT
    a0 = nadv; d0 = ndone; r0 = nrec;
    start_run(16'd1);
    wait_trig();
    puf_resp = 1'b1;
    wait_trig();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("mrst_challenge", challenge, 64'd0);
    chk("mrst_trig", {63'd0, puf_trig}, 64'd0);
    chk("mrst_lfsr_en", {63'd0, lfsr_en}, 64'd0);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_out_chal", out_chal, 64'd0);
    chk("mrst_out_ones", {56'd0, out_ones}, 64'd0);
    chk("mrst_out_resp", {63'd0, out_resp}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("mrst_no_done", 64'(ndone - d0), 64'd0);
    chk("mrst_no_adv", 64'(nadv - a0), 64'd0);
    chk("mrst_no_record", 64'(nrec - r0), 64'd0);
    chk("mrst_idle", {63'd0, busy}, 64'd0);

    start_run(16'd1);
    run_rec(3'b101, 1'b0);
    wait_done();
    @(negedge clk); #1;
    chk("post_rst_records", 64'(nrec - r0), 64'd1);
    chk("post_rst_adv", 64'(nadv - a0), 64'd1);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
